// File: rtl/aes_encrypt_controller.sv
// Iterative AES-128 encryption sequencer: one round per clock, key schedule
// advanced alongside the state, ciphertext registered with a one-cycle done.
//
// Handshake: a block is accepted on the rising edge where start=1 and ready=1.
// ready is high only while idle. done is high for exactly one cycle, and
// cyphertext is valid from that cycle until the next done.
module aes_encrypt_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [127:0] cyphertext,
  output logic [1:0]   dbgFsm
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t         fsmState;
  fsm_t         nextFsm;
  logic [127:0] stateReg;
  logic [127:0] roundKey;
  logic [3:0]   round;

  logic [127:0] roundSub;
  logic [127:0] nextKey;
  logic [127:0] roundOut;
  logic [127:0] finalOut;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gfMul(inv, inv);
      if (i != 0) inv = gfMul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns: S'(r,c) = S(r,(c+r) mod 4).
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One key-schedule step: w4..w7 from w0..w3 of the current round key.
  function automatic logic [127:0] keyStep(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, rot, sub;
    w0  = rk[127:96];
    w1  = rk[95:64];
    w2  = rk[63:32];
    w3  = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w4  = w0 ^ sub ^ {rc, 24'h0};
    w5  = w1 ^ w4;
    w6  = w2 ^ w5;
    w7  = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  function automatic logic [7:0] rconOf(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round datapath: the key step runs in parallel with the state transform.
  always_comb begin
    roundSub = shiftRows(subBytes(stateReg));
    nextKey  = keyStep(roundKey, rconOf(round));
    roundOut = mixColumns(roundSub) ^ nextKey;
    finalOut = roundSub ^ nextKey;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nextFsm = fsmState;
    ready   = 1'b0;
    done    = 1'b0;
    case (fsmState)
      IDLE: begin
        ready = 1'b1;
        if (start) nextFsm = RUN;
      end
      RUN: begin
        if (round == 4'd10) nextFsm = DONE;
      end
      DONE: begin
        done    = 1'b1;
        nextFsm = IDLE;
      end
      default: nextFsm = IDLE;
    endcase
  end

  assign dbgFsm = fsmState;

  // State register plus the round datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsmState   <= IDLE;
      stateReg   <= '0;
      roundKey   <= '0;
      round      <= 4'd0;
      cyphertext <= '0;
    end else begin
      fsmState <= nextFsm;
      case (fsmState)
        IDLE: begin
          if (start) begin
            stateReg <= plaintext ^ key;
            roundKey <= key;
            round    <= 4'd1;
          end
        end
        RUN: begin
          if (round == 4'd10) begin
            cyphertext <= finalOut;
          end else begin
            stateReg <= roundOut;
            roundKey <= nextKey;
            round    <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
